gradient_mag_dir: RTL and testbench

Downstream neighbour of the 5x5 Prewitt Gx/Gy stage. Consumes the packed vector {Gy[31:16], Gx[15:0]}, both fields 16-bit two's complement, with its valid and start-of-frame strobes. Produces three things:
- an 8-bit saturated L1 gradient magnitude;
- a 2-bit quantised gradient direction, for the non-maximum-suppression stage;
- a per-frame maximum-magnitude statistic, for adaptive thresholding.

---
 rtl/gradient_pkg.sv | 16 +
 rtl/gradient_mag_dir_strobe_delay_line.sv | 33 +++
 rtl/gradient_mag_dir.sv | 157 +++++++++++++++
 tb/tb_gradient_mag_dir.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gradient_pkg.sv
// Shared types for the gradient post-processing stages: direction codes,
// default Q8 tangent thresholds and the signed Gx/Gy pair.
package gradient_pkg;

  typedef enum logic [1:0] {DIR_0, DIR_45, DIR_90, DIR_135} dir_t;

  localparam int TAN22_Q8_DEF = 106;
  localparam int TAN67_Q8_DEF = 618;
  localparam int GRAD_W       = 16;

  typedef struct packed {
    logic signed [GRAD_W-1:0] gy;
    logic signed [GRAD_W-1:0] gx;
  } grad_pair_t;

endpackage

// File: rtl/gradient_mag_dir_strobe_delay_line.sv
// Fixed-depth shift register for sideband strobes; latency DEPTH cycles,
// never stalls, clears to zero on reset so no X strobes escape.
module strobe_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_aresetn,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  logic [DEPTH-1:0][WIDTH-1:0] shift_q, shift_d;

  always_comb begin
    shift_d    = shift_q;
    shift_d[0] = i_dat;
    for (int i = 1; i < DEPTH; i++) begin
      shift_d[i] = shift_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign o_dat = shift_q[DEPTH-1];

endmodule

// File: rtl/gradient_mag_dir.sv
// L1 gradient magnitude, quantised direction and per-frame max magnitude.
// Latency 4 cycles, free-running pipeline with no backpressure.
module gradient_mag_dir
  import gradient_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int MAG_WIDTH = 8,
  parameter int MAG_SHIFT = 2,
  parameter int TAN22_Q8  = TAN22_Q8_DEF,
  parameter int TAN67_Q8  = TAN67_Q8_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [2*IN_WIDTH-1:0] i_Gx_Gy_vector,
  input  logic                  i_data_valid,
  input  logic                  i_start_of_frame,
  output logic [MAG_WIDTH-1:0]  o_magnitude,
  output logic [1:0]            o_direction,
  output logic                  o_data_valid,
  output logic                  o_start_of_frame,
  output logic [IN_WIDTH:0]     o_frame_max_mag,
  output logic                  o_frame_max_valid
);

  localparam int PW = IN_WIDTH + 10;
  localparam logic [IN_WIDTH:0] MAG_MAX = (IN_WIDTH+1)'((1 << MAG_WIDTH) - 1);

  logic [2*IN_WIDTH-1:0] vec_q, vec_d;
  logic [IN_WIDTH-1:0]   ax_q, ax_d, ay_q, ay_d;
  logic                  sx1_q, sx1_d, sy1_q, sy1_d;
  logic [IN_WIDTH:0]     sum2_q, sum2_d;
  logic [PW-1:0]         ay256_q, ay256_d, ax22_q, ax22_d, ax67_q, ax67_d;
  logic                  sx2_q, sx2_d, sy2_q, sy2_d;
  logic [MAG_WIDTH-1:0]  mag3_q, mag3_d;
  dir_t                  dir3_q, dir3_d;
  logic [IN_WIDTH:0]     sum3_q, sum3_d;
  logic [MAG_WIDTH-1:0]  mag_q, mag_d;
  dir_t                  dir_q, dir_d;
  logic                  vld_q, vld_d, sof_q, sof_d;
  logic [IN_WIDTH:0]     run_max_q, run_max_d, fmax_q, fmax_d;
  logic                  fmax_vld_q, fmax_vld_d;
  logic [IN_WIDTH:0]     shifted;
  logic                  dl_vld, dl_sof;

  // sof only counts when it rides on a valid pixel
  strobe_delay_line #(.DEPTH(4), .WIDTH(2)) u_strobe_dl (
    .i_clk     (i_clk),
    .i_aresetn (i_aresetn),
    .i_dat     ({i_data_valid, i_start_of_frame & i_data_valid}),
    .o_dat     ({dl_vld, dl_sof})
  );

  always_comb begin
    vec_d = i_Gx_Gy_vector;

    // two's complement negate of the most negative value yields exactly 2^(W-1)
    sx1_d = vec_q[IN_WIDTH-1];
    sy1_d = vec_q[2*IN_WIDTH-1];
    ax_d  = sx1_d ? (~vec_q[IN_WIDTH-1:0] + IN_WIDTH'(1)) : vec_q[IN_WIDTH-1:0];
    ay_d  = sy1_d ? (~vec_q[2*IN_WIDTH-1:IN_WIDTH] + IN_WIDTH'(1))
                  : vec_q[2*IN_WIDTH-1:IN_WIDTH];

    sum2_d  = {1'b0, ax_q} + {1'b0, ay_q};
    ay256_d = {2'b00, ay_q, 8'h00};
    ax22_d  = PW'(ax_q) * PW'(TAN22_Q8);
    ax67_d  = PW'(ax_q) * PW'(TAN67_Q8);
    sx2_d   = sx1_q;
    sy2_d   = sy1_q;

    shifted = sum2_q >> MAG_SHIFT;
    mag3_d  = (shifted > MAG_MAX) ? '1 : shifted[MAG_WIDTH-1:0];
    sum3_d  = sum2_q;
    if (ay256_q <= ax22_q) begin
      dir3_d = DIR_0;
    end else if (ay256_q >= ax67_q) begin
      dir3_d = DIR_90;
    end else if (sx2_q == sy2_q) begin
      dir3_d = DIR_45;
    end else begin
      dir3_d = DIR_135;
    end

    mag_d = mag3_q;
    dir_d = dir3_q;
    vld_d = dl_vld;
    sof_d = dl_sof;

    run_max_d  = run_max_q;
    fmax_d     = fmax_q;
    fmax_vld_d = 1'b0;
    if (dl_vld) begin
      if (dl_sof) begin
        fmax_d     = run_max_q;
        fmax_vld_d = 1'b1;
        run_max_d  = sum3_q;
      end else if (sum3_q > run_max_q) begin
        run_max_d = sum3_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      vec_q      <= '0;
      ax_q       <= '0;
      ay_q       <= '0;
      sx1_q      <= 1'b0;
      sy1_q      <= 1'b0;
      sum2_q     <= '0;
      ay256_q    <= '0;
      ax22_q     <= '0;
      ax67_q     <= '0;
      sx2_q      <= 1'b0;
      sy2_q      <= 1'b0;
      mag3_q     <= '0;
      dir3_q     <= DIR_0;
      sum3_q     <= '0;
      mag_q      <= '0;
      dir_q      <= DIR_0;
      vld_q      <= 1'b0;
      sof_q      <= 1'b0;
      run_max_q  <= '0;
      fmax_q     <= '0;
      fmax_vld_q <= 1'b0;
    end else begin
      vec_q      <= vec_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      sx1_q      <= sx1_d;
      sy1_q      <= sy1_d;
      sum2_q     <= sum2_d;
      ay256_q    <= ay256_d;
      ax22_q     <= ax22_d;
      ax67_q     <= ax67_d;
      sx2_q      <= sx2_d;
      sy2_q      <= sy2_d;
      mag3_q     <= mag3_d;
      dir3_q     <= dir3_d;
      sum3_q     <= sum3_d;
      mag_q      <= mag_d;
      dir_q      <= dir_d;
      vld_q      <= vld_d;
      sof_q      <= sof_d;
      run_max_q  <= run_max_d;
      fmax_q     <= fmax_d;
      fmax_vld_q <= fmax_vld_d;
    end
  end

  assign o_magnitude       = mag_q;
  assign o_direction       = dir_q;
  assign o_data_valid      = vld_q;
  assign o_start_of_frame  = sof_q;
  assign o_frame_max_mag   = fmax_q;
  assign o_frame_max_valid = fmax_vld_q;

endmodule

// File: tb/tb_gradient_mag_dir.sv
// Randomised bench for gradient_mag_dir against an arithmetic reference model,
// plus literal expectations for the directed vectors and frame-max pulses.
module tb_gradient_mag_dir;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] vec = '0;
  logic        vld = 1'b0;
  logic        sof = 1'b0;
  int          cur_tag = -1;

  logic [7:0]  o_mag;
  logic [1:0]  o_dir;
  logic        o_vld, o_sof, o_fmax_vld;
  logic [16:0] o_fmax;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit vld;
    bit sof;
    int gx;
    int gy;
    int tag;
  } smp_t;

  smp_t hist [5];
  int   m_run = 0;
  int   m_fmax = 0;
  int   pulses [$];

  // directed vectors with hand-computed results
  int d_gx  [8] = '{100, 100, -100,   0, 0, 256, 256, -32768};
  int d_gy  [8] = '{  0, 100,  100, -50, 0, 106, 107,  32767};
  int d_mag [8] = '{ 25,  50,   50,  12, 0,  90,  90,    255};
  int d_dir [8] = '{  0,   1,    3,   2, 0,   0,   1,      3};

  gradient_mag_dir dut (
    .i_clk             (clk),
    .i_aresetn         (rst_n),
    .i_Gx_Gy_vector    (vec),
    .i_data_valid      (vld),
    .i_start_of_frame  (sof),
    .o_magnitude       (o_mag),
    .o_direction       (o_dir),
    .o_data_valid      (o_vld),
    .o_start_of_frame  (o_sof),
    .o_frame_max_mag   (o_fmax),
    .o_frame_max_valid (o_fmax_vld)
  );

  always #5 clk = ~clk;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int m_mag(int gx, int gy);
    int s;
    s = (iabs(gx) + iabs(gy)) / 4;
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int m_dir(int gx, int gy);
    longint ax, ay;
    ax = iabs(gx);
    ay = iabs(gy);
    if (ay * 256 <= ax * 106) return 0;
    if (ay * 256 >= ax * 618) return 2;
    if ((gx < 0) == (gy < 0)) return 1;
    return 3;
  endfunction

  task automatic check(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // record what each edge sampled; entry 4 is what the outputs must show now
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) hist[i] = '{0, 0, 0, 0, -1};
    end else begin
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = '{vld, sof, int'($signed(vec[15:0])), int'($signed(vec[31:16])), cur_tag};
    end
  end

  always @(negedge clk) begin
    smp_t s;
    int   sum;
    bit   e_vld, e_sof, e_pulse;
    if (!rst_n) begin
      m_run  = 0;
      m_fmax = 0;
      check("rst_mag", o_mag, 0);
      check("rst_dir", o_dir, 0);
      check("rst_vld", o_vld, 0);
      check("rst_sof", o_sof, 0);
      check("rst_fmax", o_fmax, 0);
      check("rst_fmax_vld", o_fmax_vld, 0);
    end else begin
      s       = hist[4];
      sum     = iabs(s.gx) + iabs(s.gy);
      e_vld   = s.vld;
      e_sof   = s.vld && s.sof;
      e_pulse = 1'b0;
      if (e_sof) begin
        m_fmax  = m_run;
        e_pulse = 1'b1;
        m_run   = sum;
      end else if (e_vld && sum > m_run) begin
        m_run = sum;
      end
      check("vld", o_vld, e_vld);
      check("sof", o_sof, e_sof);
      check("fmax_vld", o_fmax_vld, e_pulse);
      check("fmax", o_fmax, m_fmax);
      if (e_vld) begin
        check("mag", o_mag, m_mag(s.gx, s.gy));
        check("dir", o_dir, m_dir(s.gx, s.gy));
      end
      if (e_vld && s.tag >= 0) begin
        check($sformatf("lit_mag[%0d]", s.tag), o_mag, d_mag[s.tag]);
        check($sformatf("lit_dir[%0d]", s.tag), o_dir, d_dir[s.tag]);
      end
      if (o_fmax_vld) pulses.push_back(int'(o_fmax));
    end
  end

  task automatic drive(int gx, int gy, bit v, bit s, int tag);
    @(negedge clk);
    vec     = {16'(gy), 16'(gx)};
    vld     = v;
    sof     = s;
    cur_tag = tag;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    idle(3);
    #2 rst_n = 1'b1;
  endtask

  function automatic int rnd_g();
    case ($urandom_range(7))
      0:       return -32768;
      1:       return 32767;
      2:       return 0;
      3:       return int'($urandom_range(600)) - 300;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    idle(3);
    #2 rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) drive(d_gx[i], d_gy[i], 1'b1, 1'b0, i);
    idle(6);

    // frame A sums {40,300,120}, then frame B sof with sum 10
    do_reset();
    pulses.delete();
    drive(40, 0, 1'b1, 1'b1, -1);
    drive(200, 100, 1'b1, 1'b0, -1);
    drive(-60, 60, 1'b1, 1'b0, -1);
    idle(2);
    drive(0, 10, 1'b1, 1'b1, -1);
    idle(6);
    check("pulse_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check("pulse_A", pulses[0], 0);
      check("pulse_B", pulses[1], 300);
    end

    // sof without valid must be ignored
    pulses.delete();
    drive(5, 5, 1'b0, 1'b1, -1);
    idle(6);
    check("ignored_sof_pulses", pulses.size(), 0);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      drive(rnd_g(), rnd_g(), ($urandom_range(9) < 7), ($urandom_range(19) == 0), -1);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
